// File: rtl/fifo_rd_packer_pkg.sv
// Shared definitions for the FIFO read-side packer: controller states and
// the width of the transferred-word counter.
package fifo_rd_packer_pkg;

  localparam int unsigned WORD_CNT_W = 16;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_rd_packer_out_slot.sv
// Single output register with valid/ready handshake and a count of
// transferred words. The loader only asserts load when slot_free is high.
module out_slot
  import fifo_rd_packer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PACK  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [WIDTH*PACK-1:0] load_data,
  input  logic [PACK-1:0]       load_keep,
  input  logic                  out_ready,
  output logic                  slot_free,
  output logic                  out_valid,
  output logic [WIDTH*PACK-1:0] out_data,
  output logic [PACK-1:0]       out_keep,
  output logic [WORD_CNT_W-1:0] word_cnt
);

  // A draining word frees the slot in the same cycle, so a new load never bubbles.
  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      word_cnt  <= '0;
    end else begin
      if (out_valid && out_ready) begin
        word_cnt <= word_cnt + 1'b1;
      end
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= load_data;
        out_keep  <= load_keep;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Reads bytes from a sync_fifo (one-cycle read latency) and packs PACK of
// them into one output word, lane 0 first; flush emits a partial word.
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PACK  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rempty,
  output logic                  ren,
  input  logic [WIDTH-1:0]      din,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH*PACK-1:0] out_data,
  output logic [PACK-1:0]       out_keep,
  output logic [WORD_CNT_W-1:0] word_cnt
);

  localparam int unsigned CW = $clog2(PACK + 1);

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_land, cnt_nxt;
  logic                  inflight;
  logic                  flush_lat, flush_lat_nxt, flush_req;
  logic                  word_done, slot_free, load;
  logic [WIDTH*PACK-1:0] acc, acc_nxt, load_data;
  logic [PACK-1:0]       load_keep;

  // cnt_land is the lane count once this edge's in-flight byte has landed.
  assign cnt_land  = cnt + CW'(inflight);
  assign flush_req = flush | flush_lat;
  assign word_done = inflight && (cnt == CW'(PACK - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      cnt       <= '0;
      inflight  <= 1'b0;
      flush_lat <= 1'b0;
      acc       <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      inflight  <= ren & ~rempty;
      flush_lat <= flush_lat_nxt;
      acc       <= acc_nxt;
    end
  end

  always_comb begin
    acc_nxt = acc;
    for (int unsigned i = 0; i < PACK; i++) begin
      if (inflight && (cnt == CW'(i))) acc_nxt[i*WIDTH +: WIDTH] = din;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt_land;
    flush_lat_nxt = flush_lat;
    load          = 1'b0;
    unique case (state)
      FILL: begin
        // A flush coinciding with the last lane is satisfied by that full word.
        if (word_done) begin
          flush_lat_nxt = 1'b0;
          if (slot_free) begin
            load    = 1'b1;
            cnt_nxt = '0;
          end else begin
            state_nxt = HOLD;
          end
        end else if (flush_req) begin
          flush_lat_nxt = 1'b0;
          if (cnt_land != '0) state_nxt = FLUSH;
        end
      end
      HOLD, FLUSH: begin
        flush_lat_nxt = flush_lat | flush;
        if (slot_free) begin
          load      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    // rst_n gates ren directly so it drops with reset, not at the next edge.
    ren = rst_n && (state == FILL) && !rempty && (cnt_land < CW'(PACK))
          && !(flush_req && (cnt_land != '0));
    load_keep = '0;
    load_data = '0;
    for (int unsigned i = 0; i < PACK; i++) begin
      load_keep[i] = (CW'(i) < cnt_land);
      if (load_keep[i]) load_data[i*WIDTH +: WIDTH] = acc_nxt[i*WIDTH +: WIDTH];
    end
  end

  out_slot #(
    .WIDTH (WIDTH),
    .PACK  (PACK)
  ) u_out_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
    .load_keep (load_keep),
    .out_ready (out_ready),
    .slot_free (slot_free),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .word_cnt  (word_cnt)
  );

endmodule
